zuc_job_sched: RTL and testbench
================================

# zuc_job_sched

Job scheduler that shares one ZucCore keystream engine between N_REQ requesters. It accepts a KEY/IV job per requester over a valid/ready handshake and arbitrates round-robin. It sequences the core's init/start/Done protocol, captures the 32-bit Z word in the Done cycle, and returns it with the requester id. A watchdog recovers the core through its reset if Done never arrives.

## Interface
- N_REQ, 2, number of requesters (legal 2..4)
- TIMEOUT, 64, max cycles spent in WAIT before the core is declared hung (legal 40..255)
- RECOVER_CYC, 2, cycles core_rstn is held low on recovery (legal 1..15)

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- req_valid  in  N_REQ  job request per requester
- req_ready  out  N_REQ  one-hot accept; at most one bit high per cycle
- req_key  in  128*N_REQ  KEY per requester; requester i uses bits [128i+127:128i]
- req_iv  in  128*N_REQ  IV per requester; same slicing as req_key
- rsp_valid  out  1  result available
- rsp_ready  in  1  result consumed
- rsp_id  out  2  index of the requester that owns the result
- rsp_z  out  32  captured keystream word
- rsp_err  out  1  job ended by timeout; rsp_z is 0
- busy  out  1  high in every state except IDLE
- core_rstn  out  1  core reset, active-low
- core_init  out  1  core init pulse
- core_start  out  1  core start pulse
- core_key  out  128  latched KEY
- core_iv  out  128  latched IV
- core_z  in  32  core Z
- core_done  in  1  core Done

## Operation
- FSM states: IDLE, INIT, START, WAIT, RESP, RECOVER. Reset state is IDLE.
- IDLE:
  - If any req_valid is high, select the winner round-robin, starting the search at rr_ptr.
  - Drive req_ready[winner]=1 combinationally in this cycle.
  - Latch req_key/req_iv/id of the winner into core_key/core_iv/job_id, then go to INIT.
- INIT: core_init=1 for exactly one cycle, then go to START.
- START: core_start=1 for exactly one cycle. Clear the watchdog counter, then go to WAIT.
- WAIT:
  - Count cycles.
  - If core_done=1: capture rsp_z<=core_z and rsp_err<=0, then go to RESP.
  - Else, when the count reaches TIMEOUT-1: set rsp_z<=0 and rsp_err<=1, then go to RECOVER.
  - If core_done coincides with the last timeout cycle, core_done wins and the result is valid.
- RECOVER: core_rstn=0 for RECOVER_CYC cycles, then go to RESP.
- RESP:
  - rsp_valid=1. rsp_id, rsp_z and rsp_err are stable until rsp_valid && rsp_ready.
  - On that handshake: rr_ptr <= (job_id+1) mod N_REQ, then go to IDLE.
- core_key/core_iv hold their value from the accept edge until the next accept.
- core_done outside WAIT is ignored.
- req_valid dropped by a non-winning requester has no effect. No job is queued internally; one job is in flight at a time.

## Timing
Reset values:
- rsp_valid=0, rsp_z=0, rsp_err=0, rsp_id=0
- req_ready=0, core_init=0, core_start=0
- core_rstn=1, busy=0
- core_key=0, core_iv=0, rr_ptr=0

Nominal job timeline, with the accept cycle as cycle 0:
- Cycle 1 is INIT (core_init=1).
- Cycle 2 is START (core_start=1).
- The core iterates over cycles 3..36 and is in its assign state in cycle 37.
- core_done=1 in cycle 38, when core_z is captured.
- rsp_valid=1 from cycle 39.

Other timing rules:
- Earliest next accept is the cycle after the rsp handshake, giving a throughput of 1 job per 40 cycles with rsp_ready tied high.
- Timeout path: rsp_valid rises TIMEOUT+RECOVER_CYC+3 cycles after accept.
- All outputs are registered except req_ready, which is a combinational grant in IDLE.
- Reset mid-operation: every register returns to its reset value immediately and any in-flight job is lost silently. The core shares rstn and is also reset.

## Structure
- Shared zuc_pkg holds:
  - the FSM state enum (3-bit encoding)
  - ZUC_CORE_LATENCY=38 (accept to core_done)
  - the widths KEY_W=128, IV_W=128, Z_W=32
- One sub-module, zuc_rr_arbiter:
  - inputs: req vector and rr_ptr
  - outputs: one-hot grant and encoded index
  - purely combinational; reused by later multi-core schedulers.
- The watchdog counter and the RECOVER counter share one 8-bit register.

## Test plan
- Single job, key=0, iv=0 from requester 0, rsp_ready=1:
  - req_ready[0] in cycle 0, core_init in cycle 1, core_start in cycle 2, rsp_valid in cycle 39.
  - rsp_id=0, rsp_err=0, rsp_z equal to the core reference model output.
- Requesters 0 and 1 both valid continuously, distinct keys:
  - grants alternate 0,1,0,1; each rsp_id matches its grant and each rsp_z matches the model for that requester's key.
- rsp_ready held low for 20 cycles after rsp_valid:
  - rsp_valid/rsp_z/rsp_id stay constant, no req_ready asserts and busy stays 1.
  - IDLE is entered only after the handshake.
- Core stub that never asserts done, TIMEOUT=64, RECOVER_CYC=2:
  - core_rstn low in cycles 67-68, rsp_valid in cycle 69 with rsp_err=1 and rsp_z=0.
  - The next job completes normally.
- core_done asserted in the final timeout cycle: rsp_err=0 and rsp_z is captured.
- rstn pulsed low during WAIT (cycle 20):
  - all outputs at reset values, rr_ptr=0, no rsp_valid.
  - A new request after reset completes in 39 cycles.

Source files
------------

// File: rtl/zuc_pkg.sv
// Shared types and widths for the ZUC job scheduler and its arbiter.
package zuc_pkg;

  localparam int unsigned KEY_W            = 128;
  localparam int unsigned IV_W             = 128;
  localparam int unsigned Z_W              = 32;
  localparam int unsigned ID_W             = 2;
  localparam int unsigned CNT_W            = 8;
  localparam int unsigned ZUC_CORE_LATENCY = 38;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_START   = 3'd2,
    S_WAIT    = 3'd3,
    S_RESP    = 3'd4,
    S_RECOVER = 3'd5
  } zuc_state_e;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [Z_W-1:0]  z;
    logic            err;
  } zuc_rsp_t;

endpackage

// File: rtl/zuc_job_sched_if.sv
// Requester-side job bus: per-requester KEY/IV requests and a shared result channel.
interface zuc_job_sched_if #(
  parameter int unsigned N_REQ = 2
) ();
  import zuc_pkg::*;

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [KEY_W*N_REQ-1:0] req_key;
  logic [IV_W*N_REQ-1:0]  req_iv;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [Z_W-1:0]         rsp_z;
  logic                   rsp_err;

  modport master (
    output req_valid, req_key, req_iv, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_z, rsp_err
  );

  modport slave (
    input  req_valid, req_key, req_iv, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_z, rsp_err
  );
endinterface

// File: rtl/zuc_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i wins.
module zuc_rr_arbiter
  import zuc_pkg::*;
#(
  parameter int unsigned N_REQ = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  idx_o
);

  // Rotate so that bit k corresponds to requester (ptr_i + k) mod N_REQ.
  logic [N_REQ-1:0] rot;
  assign rot = N_REQ'({req_i, req_i} >> ptr_i);

  always_comb begin : p_pick
    logic        found;
    int unsigned pos;
    found = 1'b0;
    pos   = 0;
    gnt_o = '0;
    idx_o = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        pos   = 32'(ptr_i) + k;
        if (pos >= N_REQ) pos = pos - N_REQ;
      end
    end
    idx_o = ID_W'(pos);
    if (found) gnt_o = N_REQ'(1) << idx_o;
  end

endmodule

// File: rtl/zuc_job_sched.sv
// Shares one ZUC keystream core between N_REQ requesters, with a watchdog that
// resets the core when Done never arrives.
module zuc_job_sched
  import zuc_pkg::*;
#(
  parameter int unsigned N_REQ       = 2,
  parameter int unsigned TIMEOUT     = 64,
  parameter int unsigned RECOVER_CYC = 2
) (
  input  logic             clk,
  input  logic             rstn,
  zuc_job_sched_if.slave   bus,
  output logic             busy,
  output logic             core_rstn,
  output logic             core_init,
  output logic             core_start,
  output logic [KEY_W-1:0] core_key,
  output logic [IV_W-1:0]  core_iv,
  input  logic [Z_W-1:0]   core_z,
  input  logic             core_done
);

  zuc_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [IV_W-1:0]  iv_q, iv_d;
  logic [ID_W-1:0]  job_id_q, job_id_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  zuc_rsp_t         rsp_q, rsp_d;
  logic             rsp_valid_q, busy_q, core_init_q, core_start_q, core_rstn_q;
  logic [N_REQ-1:0] gnt, req_ready_c;
  logic [ID_W-1:0]  gnt_idx, ptr_next;

  zuc_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req_i (bus.req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  assign ptr_next = (job_id_q == ID_W'(N_REQ - 1)) ? '0 : job_id_q + ID_W'(1);

  // Next-state and datapath updates; req_ready is the only unregistered output.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    key_d       = key_q;
    iv_d        = iv_q;
    job_id_d    = job_id_q;
    rr_ptr_d    = rr_ptr_q;
    rsp_d       = rsp_q;
    req_ready_c = '0;
    unique case (state_q)
      S_IDLE: begin
        if (|bus.req_valid) begin
          req_ready_c = gnt;
          key_d       = KEY_W'(bus.req_key >> (32'(gnt_idx) * KEY_W));
          iv_d        = IV_W'(bus.req_iv >> (32'(gnt_idx) * IV_W));
          job_id_d    = gnt_idx;
          state_d     = S_INIT;
        end
      end
      S_INIT:  state_d = S_START;
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Done takes priority over an expiring watchdog in the same cycle.
        if (core_done) begin
          rsp_d   = '{id: job_id_q, z: core_z, err: 1'b0};
          state_d = S_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rsp_d   = '{id: job_id_q, z: '0, err: 1'b1};
          cnt_d   = '0;
          state_d = S_RECOVER;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RECOVER: begin
        if (cnt_q == CNT_W'(RECOVER_CYC - 1)) state_d = S_RESP;
        else                                  cnt_d   = cnt_q + CNT_W'(1);
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rr_ptr_d = ptr_next;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      key_q        <= '0;
      iv_q         <= '0;
      job_id_q     <= '0;
      rr_ptr_q     <= '0;
      rsp_q        <= '0;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      core_init_q  <= 1'b0;
      core_start_q <= 1'b0;
      core_rstn_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      key_q        <= key_d;
      iv_q         <= iv_d;
      job_id_q     <= job_id_d;
      rr_ptr_q     <= rr_ptr_d;
      rsp_q        <= rsp_d;
      rsp_valid_q  <= (state_d == S_RESP);
      busy_q       <= (state_d != S_IDLE);
      core_init_q  <= (state_d == S_INIT);
      core_start_q <= (state_d == S_START);
      core_rstn_q  <= (state_d != S_RECOVER);
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_q.id;
  assign bus.rsp_z     = rsp_q.z;
  assign bus.rsp_err   = rsp_q.err;
  assign busy          = busy_q;
  assign core_rstn     = core_rstn_q;
  assign core_init     = core_init_q;
  assign core_start    = core_start_q;
  assign core_key      = key_q;
  assign core_iv       = iv_q;

endmodule

// File: tb/tb_zuc_job_sched.sv
// Scoreboard bench for zuc_job_sched with a behavioural core stub of adjustable Done delay.
module tb_zuc_job_sched;
  import zuc_pkg::*;

  localparam int unsigned N   = 2;
  localparam int unsigned TMO = 64;
  localparam int unsigned RCV = 2;

  logic             clk = 1'b0;
  logic             rstn;
  logic             busy, core_rstn, core_init, core_start, core_done;
  logic [KEY_W-1:0] core_key;
  logic [IV_W-1:0]  core_iv;
  logic [Z_W-1:0]   core_z;

  always #5 clk = ~clk;

  zuc_job_sched_if #(.N_REQ(N)) bus ();

  zuc_job_sched #(.N_REQ(N), .TIMEOUT(TMO), .RECOVER_CYC(RCV)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (bus),
    .busy       (busy),
    .core_rstn  (core_rstn),
    .core_init  (core_init),
    .core_start (core_start),
    .core_key   (core_key),
    .core_iv    (core_iv),
    .core_z     (core_z),
    .core_done  (core_done)
  );

  function automatic logic [31:0] zfun(input logic [127:0] k, input logic [127:0] v);
    logic [31:0] a, b;
    a = k[31:0] ^ k[63:32] ^ k[95:64] ^ k[127:96];
    b = v[31:0] ^ v[63:32] ^ v[95:64] ^ v[127:96];
    return a ^ {b[24:0], b[31:25]} ^ 32'h9E37_79B9;
  endfunction

  // Core stub: Done fires stub_dly cycles after the start cycle; 0 means never.
  int unsigned stub_dly = 36;
  int unsigned cd = 0;
  always @(posedge clk or negedge rstn) begin
    if (!rstn)           cd <= 0;
    else if (!core_rstn) cd <= 0;
    else if (core_start) cd <= stub_dly;
    else if (cd != 0)    cd <= cd - 1;
  end
  assign core_done = (cd == 1);
  assign core_z    = zfun(core_key, core_iv);

  typedef struct {
    logic [1:0]  id;
    logic [31:0] z;
    logic        err;
    int          lat;
  } exp_t;

  exp_t         sb[$];
  exp_t         e;
  logic [127:0] key[N];
  logic [127:0] iv[N];
  int           exp_lat = ZUC_CORE_LATENCY + 1;
  logic         exp_err = 1'b0;
  int           cyc = 0, acc_cyc = 0, mdl_ptr = 0;
  int           n_run = 0, n_fail = 0, n_rsp = 0, n_acc = 0;
  int           rlow_first = 0, rlow_cnt = 0;
  logic         prev_v = 1'b0;
  logic [34:0]  held = '0;
  logic [N-1:0] eg;
  int           egi;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: grant model, scoreboard push on accept, pop and compare on response.
  always @(negedge clk) begin
    if (!rstn) begin
      sb.delete();
      mdl_ptr = 0;
      prev_v  = 1'b0;
    end else begin
      if (bus.req_ready != '0) begin
        eg  = '0;
        egi = 0;
        for (int k = N - 1; k >= 0; k--) begin
          if (bus.req_valid[(mdl_ptr + k) % N]) egi = (mdl_ptr + k) % N;
        end
        if (bus.req_valid != '0) eg[egi] = 1'b1;
        chk("grant", bus.req_ready, eg);
        chk("accept_idle", busy, 0);
        acc_cyc = cyc;
        n_acc++;
        sb.push_back('{id: 2'(egi), z: exp_err ? 32'h0 : zfun(key[egi], iv[egi]),
                       err: exp_err, lat: exp_lat});
      end
      if (core_init)  chk("init_cyc", cyc - acc_cyc, 1);
      if (core_start) chk("start_cyc", cyc - acc_cyc, 2);
      if (!core_rstn) begin
        if (rlow_cnt == 0) rlow_first = cyc - acc_cyc;
        rlow_cnt++;
      end
      if (bus.rsp_valid && !prev_v) begin
        held = {bus.rsp_id, bus.rsp_z, bus.rsp_err};
        if (sb.size() == 0) chk("rsp_unexpected", sb.size(), 1);
        else                chk("rsp_lat", cyc - acc_cyc, sb[0].lat);
      end
      if (bus.rsp_valid && prev_v) begin
        chk("rsp_hold", {bus.rsp_id, bus.rsp_z, bus.rsp_err}, held);
        chk("busy_resp", busy, 1);
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        n_rsp++;
        if (sb.size() == 0) chk("rsp_unexpected", sb.size(), 1);
        else begin
          e = sb.pop_front();
          chk("rsp_id", bus.rsp_id, e.id);
          chk("rsp_z", bus.rsp_z, e.z);
          chk("rsp_err", bus.rsp_err, e.err);
          mdl_ptr = (int'(e.id) + 1) % N;
        end
      end
      prev_v = bus.rsp_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_job(input int i, input logic [127:0] k, input logic [127:0] v);
    key[i] = k;
    iv[i]  = v;
    bus.req_key[128*i +: 128] = k;
    bus.req_iv[128*i +: 128]  = v;
  endtask

  task automatic wait_acc(input int n);
    int t = 0;
    while (n_acc < n && t < 200) begin tick(); t++; end
    chk("wait_acc", n_acc >= n, 1);
  endtask

  task automatic wait_rsp(input int n);
    int t = 0;
    while (n_rsp < n && t < 600) begin tick(); t++; end
    chk("wait_rsp", n_rsp >= n, 1);
  endtask

  task automatic chk_reset_vals();
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_z", bus.rsp_z, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_core_init", core_init, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_core_rstn", core_rstn, 1);
    chk("rst_busy", busy, 0);
    chk("rst_core_key", core_key, 0);
    chk("rst_core_iv", core_iv, 0);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int a0;
    rstn          = 1'b0;
    bus.req_valid = '0;
    bus.req_key   = '0;
    bus.req_iv    = '0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin key[i] = '0; iv[i] = '0; end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals();
    tick();
    rstn = 1'b1;

    // Single zero-key job from requester 0.
    set_job(0, '0, '0);
    bus.req_valid = 2'b01;
    wait_acc(1);
    bus.req_valid = '0;
    wait_rsp(1);

    // Both requesters continuously valid: grants alternate.
    set_job(0, rnd128(), rnd128());
    set_job(1, rnd128(), rnd128());
    bus.req_valid = 2'b11;
    wait_rsp(5);
    bus.req_valid = '0;

    // Response back-pressure for 20 cycles with the other requester waiting.
    set_job(0, rnd128(), rnd128());
    set_job(1, rnd128(), rnd128());
    bus.rsp_ready = 1'b0;
    bus.req_valid = 2'b11;
    wait_acc(6);
    a0 = n_acc;
    for (int t = 0; t < 100 && !bus.rsp_valid; t++) tick();
    repeat (20) tick();
    chk("hold_no_accept", n_acc, a0);
    chk("hold_busy", busy, 1);
    bus.rsp_ready = 1'b1;
    wait_rsp(6);
    bus.req_valid = '0;

    // Hung core: watchdog expires, core held in reset, error response.
    stub_dly = 0;
    exp_err  = 1'b1;
    exp_lat  = TMO + RCV + 3;
    rlow_cnt = 0;
    set_job(0, rnd128(), rnd128());
    bus.req_valid = 2'b01;
    wait_acc(7);
    bus.req_valid = '0;
    wait_rsp(7);
    chk("recover_first", rlow_first, TMO + 3);
    chk("recover_len", rlow_cnt, RCV);

    // Next job after recovery completes normally.
    stub_dly = 36;
    exp_err  = 1'b0;
    exp_lat  = ZUC_CORE_LATENCY + 1;
    set_job(1, rnd128(), rnd128());
    bus.req_valid = 2'b10;
    wait_acc(8);
    bus.req_valid = '0;
    wait_rsp(8);

    // Done in the final watchdog cycle still counts as a good result.
    stub_dly = TMO;
    exp_lat  = TMO + 3;
    set_job(0, rnd128(), rnd128());
    bus.req_valid = 2'b01;
    wait_acc(9);
    bus.req_valid = '0;
    wait_rsp(9);

    // Reset in the middle of WAIT drops the job and clears rr_ptr.
    stub_dly = 36;
    exp_lat  = ZUC_CORE_LATENCY + 1;
    set_job(1, rnd128(), rnd128());
    bus.req_valid = 2'b10;
    wait_acc(10);
    bus.req_valid = '0;
    for (int t = 0; t < 100 && (cyc - acc_cyc) < 20; t++) tick();
    rstn = 1'b0;
    @(negedge clk);
    chk_reset_vals();
    tick();
    rstn = 1'b1;
    repeat (45) tick();
    chk("no_rsp_after_rst", n_rsp, 9);
    chk("idle_after_rst", busy, 0);
    set_job(0, rnd128(), rnd128());
    set_job(1, rnd128(), rnd128());
    bus.req_valid = 2'b11;
    wait_acc(11);
    bus.req_valid = '0;
    wait_rsp(10);
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
